// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
// Accepts note-on/note-off events over a valid/ready handshake and maps each note onto one of
// NumVoices generator slots: re-use the slot already holding the note, else the lowest free slot,
// else steal the oldest sounding slot. One slot is examined per cycle, so each event takes
// NumVoices + 2 cycles from acceptance to ev_ready returning high.
//
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   ev_valid_i/ev_ready_o  event handshake
//   ev_note_on_i           1 = note-on, 0 = note-off (note-on with velocity 0 is a note-off)
//   ev_note_i              MIDI note number
//   ev_velocity_i          velocity
//   all_notes_off_i        panic: release every voice, drop any in-flight event
//   voice_active_o         per-slot sounding flag
//   voice_note_o           per-slot note, slot i at [i*NoteW +: NoteW]
//   voice_volume_o         per-slot volume, same packing
//   voice_retrigger_o      1-cycle pulse when a slot is (re)assigned
//   steal_o                1-cycle pulse when an active slot was stolen
module voice_allocator #(
  parameter int unsigned NumVoices = 4,
  parameter int unsigned NoteW     = 7,
  parameter int unsigned AgeW      = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       ev_valid_i,
  output logic                       ev_ready_o,
  input  logic                       ev_note_on_i,
  input  logic [NoteW-1:0]           ev_note_i,
  input  logic [NoteW-1:0]           ev_velocity_i,
  input  logic                       all_notes_off_i,
  output logic [NumVoices-1:0]       voice_active_o,
  output logic [NumVoices*NoteW-1:0] voice_note_o,
  output logic [NumVoices*NoteW-1:0] voice_volume_o,
  output logic [NumVoices-1:0]       voice_retrigger_o,
  output logic                       steal_o
);

  localparam int unsigned IdxW = $clog2(NumVoices);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumVoices - 1);
  localparam logic [AgeW-1:0] AgeMax  = '1;

  typedef enum logic [1:0] {StIdle, StScan, StApply} state_e;

  state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic ev_ready_q, ev_ready_d;

  // Latched event
  logic             ev_on_q, ev_on_d;
  logic [NoteW-1:0] ev_note_q, ev_note_d;
  logic [NoteW-1:0] ev_vel_q, ev_vel_d;

  // Scan candidates
  logic            match_found_q, match_found_d;
  logic [IdxW-1:0] match_idx_q, match_idx_d;
  logic            free_found_q, free_found_d;
  logic [IdxW-1:0] free_idx_q, free_idx_d;
  logic            old_found_q, old_found_d;
  logic [IdxW-1:0] old_idx_q, old_idx_d;
  logic [AgeW-1:0] old_age_q, old_age_d;

  // Slot state
  logic [NumVoices-1:0] active_q, active_d;
  logic [NoteW-1:0]     note_q [NumVoices];
  logic [NoteW-1:0]     note_d [NumVoices];
  logic [NoteW-1:0]     vol_q  [NumVoices];
  logic [NoteW-1:0]     vol_d  [NumVoices];
  logic [AgeW-1:0]      age_q  [NumVoices];
  logic [AgeW-1:0]      age_d  [NumVoices];

  logic [NumVoices-1:0] retrig_q, retrig_d;
  logic                 steal_q, steal_d;

  logic            accept;
  logic [IdxW-1:0] target;

  assign accept = ev_valid_i && ev_ready_q && !all_notes_off_i;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_vel_d      = ev_vel_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    active_d      = active_q;
    note_d        = note_q;
    vol_d         = vol_q;
    age_d         = age_q;
    retrig_d      = '0;
    steal_d       = 1'b0;
    target        = '0;
    // Registered view of "state is idle": low from the accepting edge until APPLY has retired.
    ev_ready_d    = (state_q == StIdle) && !accept;

    if (all_notes_off_i) begin
      state_d    = StIdle;
      ev_ready_d = 1'b1;
      active_d   = '0;
      for (int unsigned i = 0; i < NumVoices; i++) begin
        vol_d[i] = '0;
        age_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ev_on_d       = ev_note_on_i && (ev_velocity_i != '0);
            ev_note_d     = ev_note_i;
            ev_vel_d      = ev_velocity_i;
            idx_d         = '0;
            match_found_d = 1'b0;
            free_found_d  = 1'b0;
            old_found_d   = 1'b0;
            match_idx_d   = '0;
            free_idx_d    = '0;
            old_idx_d     = '0;
            old_age_d     = '0;
            state_d       = StScan;
          end
        end
        StScan: begin
          if (active_q[idx_q] && (note_q[idx_q] == ev_note_q) && !match_found_q) begin
            match_found_d = 1'b1;
            match_idx_d   = idx_q;
          end
          if (!active_q[idx_q] && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          // Strictly greater keeps the lowest index on ties.
          if (active_q[idx_q] && (!old_found_q || (age_q[idx_q] > old_age_q))) begin
            old_found_d = 1'b1;
            old_idx_d   = idx_q;
            old_age_d   = age_q[idx_q];
          end
          if (idx_q == LastIdx) begin
            state_d = StApply;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StApply: begin
          state_d = StIdle;
          if (ev_on_q) begin
            if (match_found_q) begin
              target = match_idx_q;
            end else if (free_found_q) begin
              target = free_idx_q;
            end else begin
              target = old_idx_q;
            end
            for (int unsigned i = 0; i < NumVoices; i++) begin
              if (active_q[i] && (IdxW'(i) != target) && (age_q[i] != AgeMax)) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
            active_d[target] = 1'b1;
            note_d[target]   = ev_note_q;
            vol_d[target]    = ev_vel_q;
            age_d[target]    = '0;
            retrig_d[target] = 1'b1;
            steal_d          = !match_found_q && !free_found_q;
          end else if (match_found_q) begin
            active_d[match_idx_q] = 1'b0;
            vol_d[match_idx_q]    = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      ev_ready_q    <= 1'b0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      active_q      <= '0;
      retrig_q      <= '0;
      steal_q       <= 1'b0;
      for (int unsigned i = 0; i < NumVoices; i++) begin
        note_q[i] <= '0;
        vol_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_ready_q    <= ev_ready_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_vel_q      <= ev_vel_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      active_q      <= active_d;
      retrig_q      <= retrig_d;
      steal_q       <= steal_d;
      for (int unsigned i = 0; i < NumVoices; i++) begin
        note_q[i] <= note_d[i];
        vol_q[i]  <= vol_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  always_comb begin
    voice_note_o   = '0;
    voice_volume_o = '0;
    for (int unsigned i = 0; i < NumVoices; i++) begin
      voice_note_o[i*NoteW +: NoteW]   = note_q[i];
      voice_volume_o[i*NoteW +: NoteW] = vol_q[i];
    end
  end

  assign ev_ready_o        = ev_ready_q;
  assign voice_active_o    = active_q;
  assign voice_retrigger_o = retrig_q;
  assign steal_o           = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized self-checking bench for voice_allocator against a slot-table reference model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int NW = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ev_valid = 1'b0;
  logic             ev_ready;
  logic             ev_note_on = 1'b0;
  logic [NW-1:0]    ev_note = '0;
  logic [NW-1:0]    ev_velocity = '0;
  logic             all_notes_off = 1'b0;
  logic [NV-1:0]    voice_active;
  logic [NV*NW-1:0] voice_note;
  logic [NV*NW-1:0] voice_volume;
  logic [NV-1:0]    voice_retrigger;
  logic             steal;

  voice_allocator #(.NumVoices(NV), .NoteW(NW), .AgeW(8)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .ev_valid_i       (ev_valid),
    .ev_ready_o       (ev_ready),
    .ev_note_on_i     (ev_note_on),
    .ev_note_i        (ev_note),
    .ev_velocity_i    (ev_velocity),
    .all_notes_off_i  (all_notes_off),
    .voice_active_o   (voice_active),
    .voice_note_o     (voice_note),
    .voice_volume_o   (voice_volume),
    .voice_retrigger_o(voice_retrigger),
    .steal_o          (steal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference slot table
  bit            m_act [NV];
  int            m_note[NV];
  int            m_vol [NV];
  int            m_age [NV];
  logic [NV-1:0] exp_retrig;
  logic          exp_steal;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk_act();
    logic [63:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic logic [63:0] pk_note();
    logic [63:0] r = '0;
    for (int i = 0; i < NV; i++) r[i*NW +: NW] = NW'(m_note[i]);
    return r;
  endfunction

  function automatic logic [63:0] pk_vol();
    logic [63:0] r = '0;
    for (int i = 0; i < NV; i++) r[i*NW +: NW] = NW'(m_vol[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vol[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_panic();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_vol[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_event(input bit on, input int n, input int v);
    int match = -1;
    int free = -1;
    int oldest = -1;
    int t;
    exp_retrig = '0;
    exp_steal  = 1'b0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (m_act[i] && m_note[i] == n) match = i;
      if (!m_act[i]) free = i;
    end
    for (int i = 0; i < NV; i++)
      if (m_act[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
    if (on && v != 0) begin
      t = (match >= 0) ? match : (free >= 0) ? free : oldest;
      for (int i = 0; i < NV; i++)
        if (m_act[i] && i != t && m_age[i] < 255) m_age[i]++;
      m_act[t] = 1; m_note[t] = n; m_vol[t] = v; m_age[t] = 0;
      exp_retrig[t] = 1'b1;
      exp_steal = (match < 0 && free < 0);
    end else if (match >= 0) begin
      m_act[match] = 0;
      m_vol[match] = 0;
    end
  endtask

  task automatic check_slots(input string tag);
    check_eq({tag, "_active"}, 64'(voice_active), pk_act());
    check_eq({tag, "_note"}, 64'(voice_note), pk_note());
    check_eq({tag, "_vol"}, 64'(voice_volume), pk_vol());
  endtask

  // Returns #1 after a rising edge with ev_ready high, or flags a timeout.
  task automatic wait_ready();
    int n = 0;
    while (ev_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (ev_ready !== 1'b1) check_eq("ready_timeout", 64'(ev_ready), 64'd1);
  endtask

  task automatic drive_event(input bit on, input int n, input int v);
    wait_ready();
    ev_valid = 1'b1; ev_note_on = on; ev_note = NW'(n); ev_velocity = NW'(v);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    check_eq("ready_after_accept", 64'(ev_ready), 64'd0);
  endtask

  task automatic send(input bit on, input int n, input int v);
    drive_event(on, n, v);
    model_event(on, n, v);
    repeat (5) @(posedge clk);
    #1;
    check_slots("apply");
    check_eq("retrig", 64'(voice_retrigger), 64'(exp_retrig));
    check_eq("steal", 64'(steal), 64'(exp_steal));
    @(posedge clk); #1;
    check_eq("retrig_clear", 64'(voice_retrigger), 64'd0);
    check_eq("steal_clear", 64'(steal), 64'd0);
    check_eq("ready_back", 64'(ev_ready), 64'd1);
  endtask

  // Panic while the event is in flight; d edges after acceptance (0..4).
  task automatic panic_event(input bit on, input int n, input int v, input int d);
    drive_event(on, n, v);
    repeat (d) @(posedge clk);
    #1 all_notes_off = 1'b1;
    @(posedge clk); #1;
    all_notes_off = 1'b0;
    model_panic();
    check_slots("panic");
    check_eq("panic_ready", 64'(ev_ready), 64'd1);
    check_eq("panic_retrig", 64'(voice_retrigger), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check_slots("panic_late");
    check_eq("panic_late_retrig", 64'(voice_retrigger), 64'd0);
    check_eq("panic_late_steal", 64'(steal), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_slots("reset");
    check_eq("reset_ready", 64'(ev_ready), 64'd0);
    check_eq("reset_pulses", 64'({voice_retrigger, steal}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_rise", 64'(ev_ready), 64'd1);

    // Single note-on lands in slot 0
    send(1, 60, 100);
    check_eq("tp1_active", 64'(voice_active), 64'h1);
    // Fill, then steal the oldest (slot 0)
    send(1, 62, 90); send(1, 64, 80); send(1, 67, 70);
    send(1, 69, 60);
    check_eq("tp2_slot0_note", 64'(voice_note[NW-1:0]), 64'd69);
    // Release then reuse without steal
    send(0, 62, 0); send(1, 65, 40);
    // Same note re-use, velocity-zero release
    send(1, 64, 50); send(1, 64, 90); send(1, 64, 0);
    // Unmatched note-off
    send(0, 70, 33);
    // Panic mid-scan with voices sounding
    panic_event(1, 72, 20, 2);
    send(1, 60, 10); send(1, 61, 11); send(1, 62, 12);
    panic_event(1, 63, 99, 0);

    // Reset mid-scan acts without a clock edge
    send(1, 50, 5);
    drive_event(1, 51, 6);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_slots("async_reset");
    check_eq("async_reset_ready", 64'(ev_ready), 64'd0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_rise2", 64'(ev_ready), 64'd1);

    for (int k = 0; k < 150; k++) begin
      int n = 60 + $urandom_range(0, 7);
      int v = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
      bit on = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) panic_event(on, n, v, $urandom_range(0, 4));
      else send(on, n, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
